// File: rtl/adc_dac_pkg.sv
// Shared types for the DAC->ADC loop sequencer: the 12-bit converter code type,
// the sequencer FSM state encoding and a signed-distance helper used by the
// optional readback comparator.
package adc_dac_pkg;

    localparam int CODE_W = 12;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DAC_START = 3'd1,
        ST_DAC_WAIT  = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_ADC_START = 3'd4,
        ST_ADC_WAIT  = 3'd5,
        ST_PUBLISH   = 3'd6
    } seq_state_t;

    // |a - b| computed through a 13-bit signed difference so that codes at
    // opposite ends of the range cannot alias to a small distance.
    function automatic logic [CODE_W:0] code_abs_diff(input code_t a, input code_t b);
        logic signed [CODE_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return diff[CODE_W] ? -diff : diff;
    endfunction

endpackage

// File: rtl/adc_dac_loop_sequencer_tick.sv
// Sample tick generator: free-running period counter gated by enable.
// The counter holds at zero while disabled, so the first tick after enable
// rises lands exactly PERIOD_CYCLES cycles later.
module sample_tick_gen #(
    parameter int PERIOD_CYCLES = 12500
) (
    input  logic Clk,
    input  logic Rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the period end, clear whenever the loop is disabled.
    always_comb begin
        cnt_d = '0;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Period counter register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/adc_dac_loop_sequencer.sv
// Periodic DAC->ADC loop sequencer. Each sample tick writes the next ramp
// code to the DAC driver, waits for the frame to finish plus an analog settle
// time, runs one ADC conversion and publishes the (dac, adc) pair.
// Optional readback comparator enabled by defining MISMATCH_CHECK_EN; without
// it the mismatch output is tied low.
module adc_dac_loop_sequencer
    import adc_dac_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 12500,
    parameter int SETTLE_CYCLES  = 125,
    parameter int STEP           = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TOL            = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              enable,
    output logic              dac_start,
    output logic [CODE_W-1:0] dac_code,
    input  logic              dac_done,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [CODE_W-1:0] adc_data,
    output logic              sample_valid,
    output logic [CODE_W-1:0] sample_dac,
    output logic [CODE_W-1:0] sample_adc,
    output logic              overrun,
    output logic              timeout_err,
    output logic              mismatch
);

    // Watchdog and settle counters only need to reach N-1, the +1 keeps the
    // width sane for N = 1.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam code_t           STEP_C      = code_t'(STEP % (1 << CODE_W));

    logic tick;

    sample_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_tick (
        .Clk   (Clk),
        .Rst   (Rst),
        .enable(enable),
        .tick  (tick)
    );

    seq_state_t      state_q,        state_d;
    code_t           ramp_q,         ramp_d;
    code_t           dac_code_q,     dac_code_d;
    logic [WD_W-1:0] wd_q,           wd_d;
    logic [ST_W-1:0] settle_q,       settle_d;
    logic            dac_start_q,    dac_start_d;
    logic            adc_start_q,    adc_start_d;
    logic            sample_valid_q, sample_valid_d;
    code_t           sample_dac_q,   sample_dac_d;
    code_t           sample_adc_q,   sample_adc_d;
    logic            overrun_q,      overrun_d;
    logic            timeout_q,      timeout_d;

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        ramp_d         = ramp_q;
        dac_code_d     = dac_code_q;
        wd_d           = wd_q;
        settle_d       = settle_q;
        dac_start_d    = 1'b0;
        adc_start_d    = 1'b0;
        sample_valid_d = 1'b0;
        sample_dac_d   = sample_dac_q;
        sample_adc_d   = sample_adc_q;
        timeout_d      = timeout_q;
        // A tick while a frame is in flight is dropped, only flagged.
        overrun_d      = overrun_q | (tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    dac_code_d  = ramp_q;
                    dac_start_d = 1'b1;
                    state_d     = ST_DAC_START;
                end
            end
            ST_DAC_START: begin
                wd_d    = '0;
                state_d = ST_DAC_WAIT;
            end
            ST_DAC_WAIT: begin
                if (dac_done) begin
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    adc_start_d = 1'b1;
                    state_d     = ST_ADC_START;
                end else begin
                    settle_d = settle_q + ST_W'(1);
                end
            end
            ST_ADC_START: begin
                wd_d    = '0;
                state_d = ST_ADC_WAIT;
            end
            ST_ADC_WAIT: begin
                if (adc_done) begin
                    // Sample registers double as the ADC capture so the pair
                    // is visible together with sample_valid.
                    sample_valid_d = 1'b1;
                    sample_dac_d   = dac_code_q;
                    sample_adc_d   = adc_data;
                    state_d        = ST_PUBLISH;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_PUBLISH: begin
                // Ramp only advances on a completed sample; timeouts retry the code.
                ramp_d  = ramp_q + STEP_C;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers; reset aborts any frame in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q        <= ST_IDLE;
            ramp_q         <= '0;
            dac_code_q     <= '0;
            wd_q           <= '0;
            settle_q       <= '0;
            dac_start_q    <= 1'b0;
            adc_start_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_dac_q   <= '0;
            sample_adc_q   <= '0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ramp_q         <= ramp_d;
            dac_code_q     <= dac_code_d;
            wd_q           <= wd_d;
            settle_q       <= settle_d;
            dac_start_q    <= dac_start_d;
            adc_start_q    <= adc_start_d;
            sample_valid_q <= sample_valid_d;
            sample_dac_q   <= sample_dac_d;
            sample_adc_q   <= sample_adc_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

`ifdef MISMATCH_CHECK_EN
    localparam logic [CODE_W:0] TOL_C = (CODE_W + 1)'(TOL);

    logic mismatch_q;
    logic mismatch_d;

    // Readback check on the published pair; sticky until reset.
    always_comb begin
        mismatch_d = mismatch_q;
        if ((state_q == ST_PUBLISH) &&
            (code_abs_diff(sample_adc_q, sample_dac_q) > TOL_C)) begin
            mismatch_d = 1'b1;
        end
    end

    // Mismatch flag register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    assign dac_start    = dac_start_q;
    assign dac_code     = dac_code_q;
    assign adc_start    = adc_start_q;
    assign sample_valid = sample_valid_q;
    assign sample_dac   = sample_dac_q;
    assign sample_adc   = sample_adc_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_adc_dac_loop_sequencer.sv
// Directed bench for adc_dac_loop_sequencer with small timing parameters.
// Behavioural DAC/ADC driver models answer start pulses after a programmable
// delay; the ADC model returns the current DAC code plus a programmable offset.
module tb_adc_dac_loop_sequencer;
    import adc_dac_pkg::*;

    localparam int PERIOD  = 100;
    localparam int SETTLE  = 5;
    localparam int STEP    = 1024;
    localparam int TIMEOUT = 50;
    localparam int TOL     = 8;

`ifdef MISMATCH_CHECK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst;
    logic  enable;
    logic  dac_done_m;
    logic  dac_done_s;
    logic  dac_done;
    logic  adc_done;
    code_t adc_data;
    logic  dac_start;
    code_t dac_code;
    logic  adc_start;
    logic  sample_valid;
    code_t sample_dac;
    code_t sample_adc;
    logic  overrun;
    logic  timeout_err;
    logic  mismatch;

    int    dac_delay;
    int    adc_delay;
    code_t adc_offset;

    int n_cmp = 0;
    int n_bad = 0;

    int n_dac_start;
    int n_adc_start;
    int n_sample;

    assign dac_done = dac_done_m | dac_done_s;

    always #5 clk = ~clk;

    adc_dac_loop_sequencer #(
        .PERIOD_CYCLES (PERIOD),
        .SETTLE_CYCLES (SETTLE),
        .STEP          (STEP),
        .TIMEOUT_CYCLES(TIMEOUT),
        .TOL           (TOL)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .enable      (enable),
        .dac_start   (dac_start),
        .dac_code    (dac_code),
        .dac_done    (dac_done),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .sample_valid(sample_valid),
        .sample_dac  (sample_dac),
        .sample_adc  (sample_adc),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .mismatch    (mismatch)
    );

    // Pulse counters, cleared by reset.
    always @(negedge clk) begin
        if (rst) begin
            n_dac_start = 0;
            n_adc_start = 0;
            n_sample    = 0;
        end else begin
            if (dac_start)    n_dac_start = n_dac_start + 1;
            if (adc_start)    n_adc_start = n_adc_start + 1;
            if (sample_valid) n_sample    = n_sample + 1;
        end
    end

    // DAC driver model: done pulse dac_delay cycles after start (0 = never).
    initial begin : dac_model
        dac_done_m = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (dac_start && !rst && dac_delay > 0) begin
                repeat (dac_delay) @(posedge clk);
                #1 dac_done_m = 1'b1;
                @(posedge clk);
                #1 dac_done_m = 1'b0;
            end
        end
    end

    // ADC driver model: returns dac_code + adc_offset adc_delay cycles after start.
    initial begin : adc_model
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(posedge clk); #1;
            if (adc_start && !rst && adc_delay > 0) begin
                repeat (adc_delay) @(posedge clk);
                #1;
                adc_data = dac_code + adc_offset;
                adc_done = 1'b1;
                @(posedge clk);
                #1 adc_done = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a pulse: sel 0 = dac_start, 1 = adc_start, 2 = sample_valid.
    task automatic wait_pulse(input int sel, input int limit, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk); #1;
            case (sel)
                0:       seen = dac_start;
                1:       seen = adc_start;
                default: seen = sample_valid;
            endcase
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        enable     = 1'b0;
        dac_done_s = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dac_start"},    32'(dac_start),    32'd0);
        check({tag, "_dac_code"},     32'(dac_code),     32'd0);
        check({tag, "_adc_start"},    32'(adc_start),    32'd0);
        check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_sample_dac"},   32'(sample_dac),   32'd0);
        check({tag, "_sample_adc"},   32'(sample_adc),   32'd0);
        check({tag, "_overrun"},      32'(overrun),      32'd0);
        check({tag, "_timeout"},      32'(timeout_err),  32'd0);
        check({tag, "_mismatch"},     32'(mismatch),     32'd0);
    endtask

    typedef struct {
        code_t adc_offset;
        code_t exp_dac;
        code_t exp_adc;
    } vec_t;

    initial begin : main
        vec_t vecs[5];
        logic early;

        // Ramp 0,1024,2048,3072 then wrap to 0. Offsets +8 / -8 sit exactly on
        // the tolerance boundary and must not raise mismatch.
        vecs[0] = '{adc_offset: 12'd0,    exp_dac: 12'd0,    exp_adc: 12'd0};
        vecs[1] = '{adc_offset: 12'd0,    exp_dac: 12'd1024, exp_adc: 12'd1024};
        vecs[2] = '{adc_offset: 12'd8,    exp_dac: 12'd2048, exp_adc: 12'd2056};
        vecs[3] = '{adc_offset: 12'hFF8,  exp_dac: 12'd3072, exp_adc: 12'd3064};
        vecs[4] = '{adc_offset: 12'd0,    exp_dac: 12'd0,    exp_adc: 12'd0};

        rst        = 1'b1;
        enable     = 1'b0;
        dac_done_s = 1'b0;
        dac_delay  = 10;
        adc_delay  = 10;
        adc_offset = '0;

        // Reset state and spurious dac_done in IDLE.
        do_reset();
        check_all_zero("reset");
        dac_done_s = 1'b1;
        cycles(1);
        dac_done_s = 1'b0;
        cycles(20);
        check("spur_dac_starts", 32'(n_dac_start), 32'd0);
        check("spur_adc_starts", 32'(n_adc_start), 32'd0);
        check("spur_samples",    32'(n_sample),    32'd0);
        check("spur_timeout",    32'(timeout_err), 32'd0);

        // Ramp sequence with echo readback; first tick exactly one period in.
        adc_offset = vecs[0].adc_offset;
        enable = 1'b1;
        early  = 1'b0;
        for (int i = 0; i < PERIOD - 1; i++) begin
            @(posedge clk); #1;
            if (dac_start) early = 1'b1;
        end
        check("first_tick_not_early", 32'(early), 32'd0);
        cycles(1);
        check("first_tick_dac_start", 32'(dac_start), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) wait_pulse(0, 2 * PERIOD, $sformatf("v%0d_dac_start", i));
            adc_offset = vecs[i].adc_offset;
            check($sformatf("v%0d_dac_code", i), 32'(dac_code), 32'(vecs[i].exp_dac));
            wait_pulse(2, 60, $sformatf("v%0d_sample_valid", i));
            check($sformatf("v%0d_sample_dac", i), 32'(sample_dac), 32'(vecs[i].exp_dac));
            check($sformatf("v%0d_sample_adc", i), 32'(sample_adc), 32'(vecs[i].exp_adc));
        end
        enable = 1'b0;
        cycles(3);
        check("ramp_samples",  32'(n_sample),    32'd5);
        check("ramp_overrun",  32'(overrun),     32'd0);
        check("ramp_timeout",  32'(timeout_err), 32'd0);
        check("ramp_mismatch", 32'(mismatch),    32'd0);

        // Readback offset beyond tolerance.
        do_reset();
        adc_offset = 12'd20;
        enable = 1'b1;
        wait_pulse(0, 2 * PERIOD, "mm_dac_start");
        wait_pulse(2, 60, "mm_sample_valid");
        check("mm_sample_adc", 32'(sample_adc), 32'd20);
        enable = 1'b0;
        cycles(3);
        check("mm_flag", 32'(mismatch), 32'(EXP_MM));
        adc_offset = '0;

        // DAC never answers in time: watchdog fires after TIMEOUT cycles.
        do_reset();
        dac_delay = 120;
        enable = 1'b1;
        wait_pulse(0, 2 * PERIOD, "to_dac_start");
        cycles(TIMEOUT);
        check("to_not_yet", 32'(timeout_err), 32'd0);
        cycles(1);
        check("to_fired", 32'(timeout_err), 32'd1);
        enable = 1'b0;
        cycles(100);
        check("to_no_adc_start", 32'(n_adc_start), 32'd0);
        check("to_no_sample",    32'(n_sample),    32'd0);
        check("to_one_dac",      32'(n_dac_start), 32'd1);

        // Long frame (late DAC, silent ADC) overlaps the next tick.
        do_reset();
        dac_delay = 45;
        adc_delay = 0;
        enable = 1'b1;
        wait_pulse(0, 2 * PERIOD, "ov_dac_start");
        check("ov_clear_at_start", 32'(overrun), 32'd0);
        cycles(110);
        check("ov_overrun",   32'(overrun),     32'd1);
        check("ov_timeout",   32'(timeout_err), 32'd1);
        check("ov_no_sample", 32'(n_sample),    32'd0);
        check("ov_tick_drop", 32'(n_dac_start), 32'd1);
        check("ov_adc_start", 32'(n_adc_start), 32'd1);
        enable = 1'b0;
        cycles(20);
        dac_delay = 10;
        adc_delay = 10;

        // Reset during ADC_WAIT clears everything at once.
        do_reset();
        adc_offset = 12'd7;
        enable = 1'b1;
        wait_pulse(2, 2 * PERIOD, "rs_first_sample");
        check("rs_first_adc", 32'(sample_adc), 32'd7);
        adc_delay = 20;
        wait_pulse(1, 2 * PERIOD, "rs_adc_start");
        check("rs_dac_code_before", 32'(dac_code), 32'd1024);
        cycles(5);
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check_all_zero("rs_async");
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(30);
        check("rs_stray_no_sample", 32'(n_sample),    32'd0);
        check("rs_stray_adc",       32'(sample_adc),  32'd0);
        check("rs_no_dac_start",    32'(n_dac_start), 32'd0);
        adc_delay  = 10;
        adc_offset = '0;

        // Enable dropped during SETTLE: frame completes, then silence.
        do_reset();
        enable = 1'b1;
        wait_pulse(0, 2 * PERIOD, "en_dac_start");
        cycles(12);
        enable = 1'b0;
        cycles(3 * PERIOD + 50);
        check("en_adc_start", 32'(n_adc_start), 32'd1);
        check("en_samples",   32'(n_sample),    32'd1);
        check("en_dac_start", 32'(n_dac_start), 32'd1);
        check("en_sample_dac", 32'(sample_dac), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
